// File: rtl/spi_mpu_get.sv
// SPI mode-3 master that performs one MPU register read: sends {1, addr[6:0]},
// then clocks in eight data bits and presents them on data with a finish pulse.
module spi_mpu_get #(
   parameter int CLK_DIV = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       miso,
   input  logic [7:0] addr,
   output logic       sclk,
   output logic       busy,
   output logic       finish,
   output logic       mosi,
   output logic [7:0] data
);

   localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      XFER,
      DONE
   } state_t;

   state_t          state_q;
   logic [DW-1:0]   div_q;
   logic [3:0]      bit_q;
   logic [7:0]      tx_q;
   logic [7:0]      rx_q;
   logic [7:0]      data_q;
   logic            sclk_q;
   logic            mosi_q;
   logic            busy_q;
   logic            finish_q;

   // sclk_q doubles as the phase flag: low phase first, then high phase, per bit.
   always_ff @(posedge clk) begin
      // NOTE: every register is reset here, including data; the block has no
      // arrays, so a full reset is what lets an abort leave no stale state.
      if (rst) begin
         state_q  <= IDLE;
         div_q    <= '0;
         bit_q    <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         data_q   <= '0;
         sclk_q   <= 1'b1;
         mosi_q   <= 1'b0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; each branch reads the pre-edge values,
         // so the order of assignments inside a branch does not matter.
         finish_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  tx_q    <= {1'b1, addr[6:0]};
                  mosi_q  <= 1'b1;
                  sclk_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  div_q   <= '0;
                  bit_q   <= '0;
                  state_q <= XFER;
               end
            end

            XFER: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                     if (bit_q[3]) begin
                        rx_q <= {rx_q[6:0], miso};
                     end
                  end else if (bit_q == 4'd15) begin
                     mosi_q   <= 1'b0;
                     busy_q   <= 1'b0;
                     finish_q <= 1'b1;
                     data_q   <= rx_q;
                     state_q  <= DONE;
                  end else begin
                     // Next bit: tx_q[6] is the following MSB; zeros fill in for the read half.
                     sclk_q <= 1'b0;
                     mosi_q <= tx_q[6];
                     tx_q   <= {tx_q[6:0], 1'b0};
                     bit_q  <= bit_q + 4'd1;
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end

            DONE: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sclk   = sclk_q;
   assign mosi   = mosi_q;
   assign busy   = busy_q;
   assign finish = finish_q;
   assign data   = data_q;

endmodule

// File: tb/tb_spi_mpu_get.sv
// Scoreboard bench for spi_mpu_get: directed reads push expectations, and a
// negedge monitor checks waveform timing, shifted frames and read data.
module tb_spi_mpu_get;

   localparam int CD = 8;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       start = 1'b0;
   logic       miso  = 1'b0;
   logic [7:0] addr  = 8'h00;
   logic       sclk;
   logic       busy;
   logic       finish;
   logic       mosi;
   logic [7:0] data;

   spi_mpu_get #(.CLK_DIV(CD)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .miso   (miso),
      .addr   (addr),
      .sclk   (sclk),
      .busy   (busy),
      .finish (finish),
      .mosi   (mosi),
      .data   (data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] tx;
      logic [7:0] rd;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   logic rst_smp = 1'b0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_smp <= rst;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: no sclk fall within %0d cycles", name, 4 * CD);
   endtask

   // ------------------------------------------------------------------ monitor
   logic        p_sclk = 1'b1;
   logic        p_mosi = 1'b0;
   logic        p_busy = 1'b0;
   int          run_len = 0;
   int          rises = 0;
   int          busy_cnt = 0;
   int          start_cyc = 0;
   logic [15:0] frame = '0;
   logic [7:0]  held = 8'h00;
   exp_t        e;

   always @(negedge clk) begin
      if (rst_smp) begin
         check("rst_sclk", sclk, 1'b1);
         check("rst_busy", busy, 1'b0);
         check("rst_mosi", mosi, 1'b0);
         check("rst_finish", finish, 1'b0);
         check("rst_data", data, 8'h00);
         rises    = 0;
         busy_cnt = 0;
         frame    = '0;
         run_len  = 0;
         held     = 8'h00;
      end else begin
         if (busy && !p_busy) begin
            start_cyc = cyc;
            busy_cnt  = 0;
            rises     = 0;
            frame     = '0;
         end
         if (busy) busy_cnt++;

         if (sclk !== p_sclk) begin
            if (sclk) begin
               check("low_half", run_len, CD);
               rises++;
               frame = {frame[14:0], mosi};
            end else if (rises > 0) begin
               check("high_half", run_len, CD);
            end
            run_len = 1;
         end else begin
            run_len++;
         end

         if (mosi !== p_mosi) check("mosi_on_fall", {p_sclk, sclk}, 2'b10);

         if (!busy) begin
            check("idle_sclk", sclk, 1'b1);
            check("idle_mosi", mosi, 1'b0);
         end

         if (finish) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_finish: finish high with no read outstanding (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               check("read_data", data, e.rd);
               check("mosi_frame", frame, {e.tx, 8'h00});
               check("sclk_rises", rises, 16);
               check("busy_cycles", busy_cnt, 32 * CD);
               // Edges from the one that samples start through the one that raises finish.
               check("latency", cyc - start_cyc + 1, 1 + 32 * CD);
               check("finish_busy", busy, 1'b0);
               held = e.rd;
            end
         end else begin
            check("data_hold", data, held);
         end
      end
      p_sclk = sclk;
      p_mosi = mosi;
      p_busy = busy;
   end

   // ---------------------------------------------------------------- stimulus
   task automatic wait_fall(output bit ok);
      logic s0;
      ok = 1'b0;
      for (int i = 0; i < 4 * CD; i++) begin
         s0 = sclk;
         @(posedge clk);
         #1;
         if (s0 && !sclk) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Issue one read; miso carries pat on bits 8-15. mid_k re-pulses start at that
   // bit, abort_k asserts rst at that bit (no expectation is queued then).
   task automatic run_txn(input logic [7:0] a, input logic [7:0] pat,
                          input logic [7:0] exp_tx, input logic [7:0] exp_rd,
                          input bit hold, input int mid_k, input int abort_k);
      bit   ok;
      exp_t x;
      addr = a;
      if (abort_k < 0) begin
         x.tx = exp_tx;
         x.rd = exp_rd;
         sb.push_back(x);
      end
      start = 1'b1;
      for (int k = 0; k < 16; k++) begin
         wait_fall(ok);
         if (!ok) begin
            timeout_fail("sclk_fall_timeout");
            start = 1'b0;
            return;
         end
         if (k == 0) start = hold;
         miso = (k >= 8) ? pat[15 - k] : 1'b1;
         if (k == mid_k) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
         end
         if (k == abort_k) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      run_txn(8'hB7, 8'hFF, 8'hB7, 8'hFF, 1'b0, -1, -1);
      repeat (3 * CD) @(posedge clk);
      #1;
      run_txn(8'h37, 8'hA5, 8'hB7, 8'hA5, 1'b0, -1, -1);
      repeat (3 * CD) @(posedge clk);
      #1;
      run_txn(8'h00, 8'h3C, 8'h80, 8'h3C, 1'b0, 10, -1);
      repeat (3 * CD) @(posedge clk);
      #1;
      // Back-to-back: start stays high across the first read.
      run_txn(8'h7F, 8'h01, 8'hFF, 8'h01, 1'b1, -1, -1);
      run_txn(8'h80, 8'hC3, 8'h80, 8'hC3, 1'b0, -1, -1);
      repeat (3 * CD) @(posedge clk);
      #1;
      run_txn(8'h12, 8'h77, 8'h92, 8'h77, 1'b0, -1, 10);
      repeat (4) @(posedge clk);
      #1;
      run_txn(8'h5A, 8'h96, 8'hDA, 8'h96, 1'b0, -1, -1);
      repeat (3 * CD) @(posedge clk);
      #1;

      check("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
